// File: rtl/tmr_pkg.sv
// Shared definitions for the triplicated scrubbed register bank:
// scrubber state encoding, copy indices and the bitwise majority voter.
package tmr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FIX   = 2'd2,
        NEXT  = 2'd3
    } scrub_state_t;

    localparam logic [1:0] COPY0 = 2'd0;
    localparam logic [1:0] COPY1 = 2'd1;
    localparam logic [1:0] COPY2 = 2'd2;

    // Voter operands are carried at a fixed maximum width; callers zero-extend
    // their words and truncate the result back to their own width.
    localparam int MAJ_W = 64;

    function automatic logic [MAJ_W-1:0] maj3(input logic [MAJ_W-1:0] a,
                                              input logic [MAJ_W-1:0] b,
                                              input logic [MAJ_W-1:0] d);
        return (a & b) | (b & d) | (a & d);
    endfunction

endpackage

// File: rtl/tmr_scrub_fsm.sv
// Background scrubber control: walks the scan pointer, compares the three
// copies at that address, schedules write-back of the voted word and keeps
// the correction report (last address, disagreeing copies, saturating count).
module tmr_scrub_fsm
    import tmr_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNTW           = 8
) (
    input  logic             c,
    input  logic             r,
    input  logic             scrub_en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] q0,
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    output logic [AW-1:0]    ptr,
    output logic             checking,
    output logic             fix_we,
    output logic [WIDTH-1:0] fix_data,
    output logic             busy,
    output logic             done,
    output logic             err_pulse,
    output logic [AW-1:0]    err_addr,
    output logic [2:0]       err_copy,
    output logic [CNTW-1:0]  err_cnt
);

    localparam int            IW       = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [IW-1:0] IVL_LAST = IW'(SCRUB_INTERVAL - 1);
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

    scrub_state_t     state, state_nx;
    logic [AW-1:0]    ptr_nx;
    logic [IW-1:0]    ivl, ivl_nx;
    logic [WIDTH-1:0] vote;
    logic [2:0]       mism;
    logic [WIDTH-1:0] fix_val;
    logic [2:0]       fix_mask;

    assign vote = WIDTH'(maj3(MAJ_W'(q0), MAJ_W'(q1), MAJ_W'(q2)));
    assign mism = {|(q2 ^ vote), |(q1 ^ vote), |(q0 ^ vote)};

    // A user write to the address being repaired supersedes the repair.
    assign fix_we   = (state == FIX) && !(wr_en && (wr_addr == ptr));
    assign fix_data = fix_val;
    assign checking = (state == CHECK);
    assign busy     = (state != IDLE);

    // Next-state, pointer advance and interval counting.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        ivl_nx   = ivl;
        case (state)
            IDLE: begin
                if (scrub_en) begin
                    if (ivl == IVL_LAST) begin
                        ivl_nx   = '0;
                        state_nx = CHECK;
                    end else begin
                        ivl_nx = ivl + 1'b1;
                    end
                end
            end
            CHECK: state_nx = (mism != 3'b000) ? FIX : NEXT;
            FIX:   state_nx = NEXT;
            NEXT: begin
                if (ptr == LAST) begin
                    ptr_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    ptr_nx   = ptr + 1'b1;
                    state_nx = scrub_en ? CHECK : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, scan pointer and interval counter registers.
    always_ff @(posedge c) begin
        if (r) begin
            state <= IDLE;
            ptr   <= '0;
            ivl   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            ivl   <= ivl_nx;
        end
    end

    // Capture the voted word and disagreement mask when a mismatch is seen.
    always_ff @(posedge c) begin
        if (checking && (mism != 3'b000)) begin
            fix_val  <= vote;
            fix_mask <= mism;
        end
    end

    // Correction report and end-of-pass pulse.
    always_ff @(posedge c) begin
        if (r) begin
            done      <= 1'b0;
            err_pulse <= 1'b0;
            err_addr  <= '0;
            err_copy  <= '0;
            err_cnt   <= '0;
        end else begin
            done      <= (state == NEXT) && (ptr == LAST);
            err_pulse <= fix_we;
            if (fix_we) begin
                err_addr <= ptr;
                err_copy <= fix_mask;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmr_scrub_bank.sv
// Triplicated DEPTH x WIDTH register bank with a registered majority-voted
// read port, fault injection for test, and a background scrubber that
// writes the voted word back wherever the copies disagree.
module tmr_scrub_bank
    import tmr_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNTW           = 8
) (
    input  logic             c,
    input  logic             r,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             scrub_en,
    input  logic             inj_en,
    input  logic [1:0]       inj_copy,
    input  logic [AW-1:0]    inj_addr,
    input  logic [WIDTH-1:0] inj_mask,
    output logic             scrub_busy,
    output logic             scrub_done,
    output logic             err_pulse,
    output logic [AW-1:0]    err_addr,
    output logic [2:0]       err_copy,
    output logic [CNTW-1:0]  err_cnt
);

    logic [WIDTH-1:0] mem     [3][DEPTH];
    logic [WIDTH-1:0] pend    [3];
    logic [WIDTH-1:0] fixw    [3];
    logic [WIDTH-1:0] inj_val [3];
    logic [2:0]       inj_hit;
    logic [AW-1:0]    ptr;
    logic             checking;
    logic             fix_we;
    logic [WIDTH-1:0] fix_data;

    assign inj_hit = {3{inj_en}} & {inj_copy == COPY2, inj_copy == COPY1, inj_copy == COPY0};

    tmr_scrub_fsm #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .AW             (AW),
        .SCRUB_INTERVAL (SCRUB_INTERVAL),
        .CNTW           (CNTW)
    ) u_fsm (
        .c         (c),
        .r         (r),
        .scrub_en  (scrub_en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .q0        (mem[0][ptr]),
        .q1        (mem[1][ptr]),
        .q2        (mem[2][ptr]),
        .ptr       (ptr),
        .checking  (checking),
        .fix_we    (fix_we),
        .fix_data  (fix_data),
        .busy      (scrub_busy),
        .done      (scrub_done),
        .err_pulse (err_pulse),
        .err_addr  (err_addr),
        .err_copy  (err_copy),
        .err_cnt   (err_cnt)
    );

    // An injection landing on the scan address during CHECK is remembered so
    // the following repair re-applies it, keeping the upset latent.
    always_ff @(posedge c) begin
        for (int k = 0; k < 3; k++)
            pend[k] <= (checking && inj_hit[k] && (inj_addr == ptr)) ? inj_mask : '0;
    end

    // Per-copy repair word and injection result; injection acts on the word
    // the same edge is writing (user write first, then repair), else on storage.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            fixw[k] = fix_data ^ pend[k];
            if (wr_en && (wr_addr == inj_addr))
                inj_val[k] = wr_data ^ inj_mask;
            else if (fix_we && (ptr == inj_addr))
                inj_val[k] = fixw[k] ^ inj_mask;
            else
                inj_val[k] = mem[k][inj_addr] ^ inj_mask;
        end
    end

    // Storage update: repair, then user write, then injection, later ones winning.
    always_ff @(posedge c) begin
        if (r) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < DEPTH; i++)
                    mem[k][i] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (fix_we)
                    mem[k][ptr] <= fixw[k];
                if (wr_en)
                    mem[k][wr_addr] <= wr_data;
                if (inj_hit[k])
                    mem[k][inj_addr] <= inj_val[k];
            end
        end
    end

    // Registered voted read; sees storage as it was before this edge.
    always_ff @(posedge c) begin
        if (r)
            rd_data <= '0;
        else
            rd_data <= WIDTH'(maj3(MAJ_W'(mem[0][rd_addr]), MAJ_W'(mem[1][rd_addr]),
                                   MAJ_W'(mem[2][rd_addr])));
    end

endmodule

// File: tb/tb_tmr_scrub_bank.sv
// Directed self-checking bench for tmr_scrub_bank.
module tb_tmr_scrub_bank;
    import tmr_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SI    = 64;
    localparam int CNTW  = 8;

    logic             c = 1'b0;
    logic             r;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             scrub_en;
    logic             inj_en;
    logic [1:0]       inj_copy;
    logic [AW-1:0]    inj_addr;
    logic [WIDTH-1:0] inj_mask;
    logic             scrub_busy;
    logic             scrub_done;
    logic             err_pulse;
    logic [AW-1:0]    err_addr;
    logic [2:0]       err_copy;
    logic [CNTW-1:0]  err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 c = ~c;

    tmr_scrub_bank #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .SCRUB_INTERVAL(SI), .CNTW(CNTW)
    ) dut (
        .c(c), .r(r), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .scrub_en(scrub_en),
        .inj_en(inj_en), .inj_copy(inj_copy), .inj_addr(inj_addr), .inj_mask(inj_mask),
        .scrub_busy(scrub_busy), .scrub_done(scrub_done), .err_pulse(err_pulse),
        .err_addr(err_addr), .err_copy(err_copy), .err_cnt(err_cnt)
    );

    task automatic inject(input logic [1:0] cp, input logic [AW-1:0] a, input logic [WIDTH-1:0] m);
        inj_en = 1'b1; inj_copy = cp; inj_addr = a; inj_mask = m;
        @(negedge c);
        inj_en = 1'b0;
    endtask

    task automatic run_until_done(input int max, output int pulses, output bit ok);
        pulses = 0;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge c);
            if (err_pulse) pulses++;
            if (scrub_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        r = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        scrub_en = 1'b0; inj_en = 1'b0; inj_copy = '0; inj_addr = '0; inj_mask = '0;
        repeat (3) @(negedge c);
        r = 1'b0;
        n_total++; if (scrub_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", scrub_busy); else n_pass++;
        n_total++; if (err_cnt !== 8'h00) $display("FAIL reset_cnt: got %h want 00", err_cnt); else n_pass++;
        n_total++; if ({err_pulse, scrub_done} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {err_pulse, scrub_done}); else n_pass++;
        n_total++; if ({err_addr, err_copy} !== 7'h00) $display("FAIL reset_err_regs: got %h want 00", {err_addr, err_copy}); else n_pass++;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            @(negedge c);
            n_total++; if (rd_data !== 8'h00) $display("FAIL reset_read[%0d]: got %h want 00", a, rd_data); else n_pass++;
        end
    endtask

    task automatic test_single_fix();
        int pl;
        bit ok, got;
        rd_addr = 4'd3; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        @(negedge c);
        wr_en = 1'b0;
        n_total++; if (rd_data !== 8'h00) $display("FAIL read_old_data: got %h want 00", rd_data); else n_pass++;
        @(negedge c);
        n_total++; if (rd_data !== 8'hA5) $display("FAIL read_new_data: got %h want a5", rd_data); else n_pass++;
        inject(COPY1, 4'd3, 8'h01);
        n_total++; if (dut.mem[1][3] !== 8'hA4) $display("FAIL inj_copy1: got %h want a4", dut.mem[1][3]); else n_pass++;
        @(negedge c);
        n_total++; if (rd_data !== 8'hA5) $display("FAIL voted_read: got %h want a5", rd_data); else n_pass++;
        // write and inject the same address in one cycle
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h11;
        inj_en = 1'b1; inj_copy = COPY0; inj_addr = 4'd4; inj_mask = 8'h01;
        @(negedge c);
        wr_en = 1'b0; inj_en = 1'b0;
        n_total++; if ({dut.mem[0][4], dut.mem[1][4], dut.mem[2][4]} !== 24'h101111)
            $display("FAIL wr_inj_same: got %h want 101111", {dut.mem[0][4], dut.mem[1][4], dut.mem[2][4]}); else n_pass++;
        scrub_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge c);
            if (err_pulse) begin got = 1'b1; break; end
        end
        n_total++; if (!got) $display("FAIL first_pulse: got none want pulse within 200 cycles"); else n_pass++;
        n_total++; if ({err_addr, err_copy, err_cnt} !== {4'd3, 3'b010, 8'd1})
            $display("FAIL fix3_report: got addr=%0d copy=%b cnt=%0d want 3 010 1", err_addr, err_copy, err_cnt); else n_pass++;
        run_until_done(100, pl, ok);
        scrub_en = 1'b0;
        n_total++; if (!ok || pl != 1) $display("FAIL pass1_end: got done=%b pulses=%0d want 1 1", ok, pl); else n_pass++;
        n_total++; if ({err_addr, err_copy, err_cnt} !== {4'd4, 3'b001, 8'd2})
            $display("FAIL fix4_report: got addr=%0d copy=%b cnt=%0d want 4 001 2", err_addr, err_copy, err_cnt); else n_pass++;
        n_total++; if ({dut.mem[0][3], dut.mem[1][3], dut.mem[2][3], dut.mem[0][4], dut.mem[1][4], dut.mem[2][4]} !== 48'hA5A5A5111111)
            $display("FAIL fix34_contents: got %h want a5a5a5111111",
                     {dut.mem[0][3], dut.mem[1][3], dut.mem[2][3], dut.mem[0][4], dut.mem[1][4], dut.mem[2][4]}); else n_pass++;
    endtask

    task automatic test_multi_copy();
        int pl;
        bit ok;
        inject(COPY0, 4'd5, 8'h01);
        inject(COPY2, 4'd5, 8'h80);
        inject(2'd3, 4'd6, 8'hFF);
        n_total++; if ({dut.mem[0][5], dut.mem[1][5], dut.mem[2][5]} !== 24'h010080)
            $display("FAIL multi_inject: got %h want 010080", {dut.mem[0][5], dut.mem[1][5], dut.mem[2][5]}); else n_pass++;
        n_total++; if ({dut.mem[0][6], dut.mem[1][6], dut.mem[2][6]} !== 24'h000000)
            $display("FAIL copy3_ignored: got %h want 000000", {dut.mem[0][6], dut.mem[1][6], dut.mem[2][6]}); else n_pass++;
        scrub_en = 1'b1;
        run_until_done(200, pl, ok);
        scrub_en = 1'b0;
        n_total++; if (!ok || pl != 1) $display("FAIL multi_pass: got done=%b pulses=%0d want 1 1", ok, pl); else n_pass++;
        n_total++; if ({err_addr, err_copy, err_cnt} !== {4'd5, 3'b101, 8'd3})
            $display("FAIL multi_report: got addr=%0d copy=%b cnt=%0d want 5 101 3", err_addr, err_copy, err_cnt); else n_pass++;
        n_total++; if ({dut.mem[0][5], dut.mem[1][5], dut.mem[2][5]} !== 24'h000000)
            $display("FAIL multi_contents: got %h want 000000", {dut.mem[0][5], dut.mem[1][5], dut.mem[2][5]}); else n_pass++;
    endtask

    task automatic test_fix_collision();
        int pl, p2;
        bit ok, hit;
        inject(COPY2, 4'd7, 8'h0F);
        scrub_en = 1'b1;
        hit = 1'b0; pl = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge c);
            if (err_pulse) pl++;
            if (dut.u_fsm.state == FIX && dut.u_fsm.ptr == 4'd7) begin
                wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
                hit = 1'b1;
                break;
            end
        end
        n_total++; if (!hit) $display("FAIL fix7_reached: got none want FIX at addr 7 within 200 cycles"); else n_pass++;
        @(negedge c);
        wr_en = 1'b0;
        if (err_pulse) pl++;
        run_until_done(100, p2, ok);
        scrub_en = 1'b0;
        n_total++; if (!ok || (pl + p2) != 0) $display("FAIL collide_pulses: got done=%b pulses=%0d want 1 0", ok, pl + p2); else n_pass++;
        n_total++; if (err_cnt !== 8'd3) $display("FAIL collide_cnt: got %0d want 3", err_cnt); else n_pass++;
        n_total++; if ({dut.mem[0][7], dut.mem[1][7], dut.mem[2][7]} !== 24'h3C3C3C)
            $display("FAIL collide_contents: got %h want 3c3c3c", {dut.mem[0][7], dut.mem[1][7], dut.mem[2][7]}); else n_pass++;
    endtask

    task automatic test_resume();
        bit hit;
        int t_chk, t_done;
        logic [AW-1:0] p_chk;
        scrub_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge c);
            if (dut.u_fsm.state == CHECK && dut.u_fsm.ptr == 4'd9) begin
                scrub_en = 1'b0;
                hit = 1'b1;
                break;
            end
        end
        n_total++; if (!hit) $display("FAIL check9_reached: got none want CHECK at addr 9 within 200 cycles"); else n_pass++;
        repeat (2) @(negedge c);
        n_total++; if ({scrub_busy, dut.u_fsm.ptr} !== {1'b0, 4'd10})
            $display("FAIL paused: got busy=%b ptr=%0d want 0 10", scrub_busy, dut.u_fsm.ptr); else n_pass++;
        repeat (20) @(negedge c);
        n_total++; if ({scrub_busy, dut.u_fsm.ptr} !== {1'b0, 4'd10})
            $display("FAIL pause_held: got busy=%b ptr=%0d want 0 10", scrub_busy, dut.u_fsm.ptr); else n_pass++;
        scrub_en = 1'b1;
        t_chk = 0; t_done = 0; p_chk = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge c);
            if (t_chk == 0 && dut.u_fsm.state == CHECK) begin
                t_chk = i;
                p_chk = dut.u_fsm.ptr;
            end
            if (scrub_done) begin
                t_done = i;
                break;
            end
        end
        scrub_en = 1'b0;
        n_total++; if (t_chk != SI || p_chk !== 4'd10)
            $display("FAIL resume_check: got cycle=%0d ptr=%0d want %0d 10", t_chk, p_chk, SI); else n_pass++;
        n_total++; if (t_done != SI + 12) $display("FAIL resume_done: got cycle=%0d want %0d", t_done, SI + 12); else n_pass++;
        @(negedge c);
        n_total++; if (scrub_done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", scrub_done); else n_pass++;
    endtask

    task automatic test_saturate();
        int pl, total;
        bit ok, all_ok;
        total = 0; all_ok = 1'b1;
        for (int p = 0; p < 19; p++) begin
            for (int a = 0; a < DEPTH; a++)
                inject(2'((p + a) % 3), AW'(a), WIDTH'(1 << ((a + p) % 8)));
            scrub_en = 1'b1;
            run_until_done(200, pl, ok);
            scrub_en = 1'b0;
            total += pl;
            if (!ok) all_ok = 1'b0;
            if (p == 7) begin
                n_total++; if (err_cnt !== 8'd131) $display("FAIL cnt_after_8: got %0d want 131", err_cnt); else n_pass++;
            end
        end
        n_total++; if (!all_ok || total != 304) $display("FAIL sat_pulses: got done_all=%b pulses=%0d want 1 304", all_ok, total); else n_pass++;
        n_total++; if (err_cnt !== 8'hFF) $display("FAIL sat_cnt: got %0d want 255", err_cnt); else n_pass++;
        n_total++; if ({err_addr, err_copy} !== {4'd15, 3'b001})
            $display("FAIL sat_last: got addr=%0d copy=%b want 15 001", err_addr, err_copy); else n_pass++;
    endtask

    task automatic test_reset_midpass();
        bit hit;
        inject(COPY1, 4'd2, 8'h40);
        scrub_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge c);
            if (dut.u_fsm.state == FIX && dut.u_fsm.ptr == 4'd2) begin
                r = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        n_total++; if (!hit) $display("FAIL fix2_reached: got none want FIX at addr 2 within 200 cycles"); else n_pass++;
        @(negedge c);
        r = 1'b0; scrub_en = 1'b0;
        n_total++; if ({scrub_busy, err_pulse, err_cnt} !== 10'h000)
            $display("FAIL midpass_reset: got busy=%b pulse=%b cnt=%0d want 0 0 0", scrub_busy, err_pulse, err_cnt); else n_pass++;
        n_total++; if ({dut.mem[0][2], dut.mem[1][2], dut.mem[2][2], dut.mem[0][3]} !== 32'h0)
            $display("FAIL midpass_clear: got %h want 00000000", {dut.mem[0][2], dut.mem[1][2], dut.mem[2][2], dut.mem[0][3]}); else n_pass++;
        @(negedge c);
        n_total++; if ({err_pulse, err_cnt} !== 9'h000) $display("FAIL midpass_no_fix: got pulse=%b cnt=%0d want 0 0", err_pulse, err_cnt); else n_pass++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_fix();
        test_multi_copy();
        test_fix_collision();
        test_resume();
        test_saturate();
        test_reset_midpass();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tmr_scrub_bank.md
Name: tmr_scrub_bank

Overview:
- Triplicated register bank (three copies of DEPTH x WIDTH storage) with a per-bit majority-voted read port.
- Background scrubber walks every address, compares the three copies and writes the voted value back on any disagreement.
- Single-copy upsets are corrected before they accumulate, and each correction is reported.
- Sits beside the triplicated flop/latch cells as the read/repair side of the TMR storage; used for configuration and state tables in radiation-tolerant designs.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of words; power of two, minimum 2.
- AW, 4, address width; must equal log2(DEPTH).
- SCRUB_INTERVAL, 64, idle cycles between scrub passes; minimum 1.
- CNTW, 8, width of the saturating correction counter.

Ports:
- c  in  1  clock; all logic on the rising edge.
- r  in  1  reset; synchronous, active-high.
- wr_en  in  1  write strobe; writes all three copies.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_addr  in  AW  read address.
- rd_data  out  WIDTH  voted read data, registered.
- scrub_en  in  1  enables background scrubbing.
- inj_en  in  1  fault-injection strobe, for test use only.
- inj_copy  in  2  target copy: 0, 1 or 2; the value 3 is ignored.
- inj_addr  in  AW  injection address.
- inj_mask  in  WIDTH  bits XORed into the target copy.
- scrub_busy  out  1  high while the FSM is not in IDLE.
- scrub_done  out  1  one-cycle pulse when a pass finishes address DEPTH-1.
- err_pulse  out  1  one-cycle pulse when a correction is written back.
- err_addr  out  AW  address of the last correction; held until the next one.
- err_copy  out  3  bit k set when copy k disagreed with the vote; held like err_addr.
- err_cnt  out  CNTW  corrections since reset; saturates at all-ones.

Behaviour:
- Reset (r=1 on a clock edge):
  - All three copies cleared to 0.
  - FSM to IDLE; scan pointer = 0; interval counter = 0.
  - rd_data, err_addr, err_copy and err_cnt = 0.
  - scrub_busy, scrub_done and err_pulse = 0.
  - Reset asserted mid-pass aborts the pass; no write-back occurs on that edge.
- Vote: bitwise (a&b)|(b&c)|(a&c) over the three copies.
- Read:
  - rd_data = vote(rd_addr) one cycle after rd_addr is presented.
  - A same-cycle write to rd_addr is not visible; old data is returned.
- Write: wr_en updates all three copies of wr_addr at the clock edge.
- Injection: inj_en XORs inj_mask into the copy selected by inj_copy at inj_addr.
  - If it coincides with a write to the same address, the target copy receives wr_data^inj_mask.
- FSM states:
  - IDLE:
    - Interval counter increments while scrub_en=1 and holds while scrub_en=0.
    - At SCRUB_INTERVAL-1 the counter clears and the FSM goes to CHECK.
  - CHECK (1 cycle per address):
    - Reads the three copies at the scan pointer.
    - All equal: go to NEXT.
    - Any mismatch: latch the vote and the err_copy mask (copy k disagrees with the vote on any bit), then go to FIX.
  - FIX (1 cycle):
    - Writes the latched vote into all three copies.
    - Pulses err_pulse, updates err_addr/err_copy, increments err_cnt (saturating).
    - Then goes to NEXT.
  - NEXT:
    - Pointer == DEPTH-1: pointer wraps to 0, scrub_done pulses, go to IDLE.
    - Otherwise pointer+1; go to CHECK if scrub_en=1, else IDLE with the pointer held, so the pass resumes later.
- Collisions during FIX:
  - wr_en to the same address as the fix: the user write wins; the fix is cancelled; no err_pulse; err_cnt unchanged.
  - wr_en to a different address: both writes take effect.
  - inj_en to the scan address in the CHECK or FIX cycle: the injection is applied after the fix write, so it remains latent until the next pass.
- Multi-copy disagreement: if different copies are wrong in different bits, the per-bit vote still corrects it and err_copy shows several bits set. If two copies carry the same wrong bit, the vote follows them silently; this is a documented limitation.

Decomposition:
- Shared package tmr_pkg:
  - FSM state enum {IDLE, CHECK, FIX, NEXT}.
  - Copy-index constants COPY0..COPY2.
  - Voter function maj3(a,b,c).
- One sub-module tmr_scrub_fsm holds the scan pointer, interval counter, state, error latches and counter.
- Storage and the vote stay in the top level.

Test Plan:
- Reset, then read all addresses -> rd_data=0; err_cnt=0; scrub_busy=0.
- Write 0xA5 to addr 3; inject mask 0x01 into copy 1 at addr 3; read addr 3 -> 0xA5. At the next pass CHECK of addr 3 -> err_pulse, err_addr=3, err_copy=3'b010, err_cnt=1. Afterwards all copies hold 0xA5.
- Inject 0x01 into copy0 and 0x80 into copy2, both at addr 5 (data 0x00) -> fix restores 0x00; err_copy=3'b101; err_cnt increments by 1.
- During FIX of addr 7, write 0x3C to addr 7 -> all copies hold 0x3C; no err_pulse; err_cnt unchanged.
- Inject at 300 distinct addr/passes with CNTW=8 -> err_cnt saturates at 255.
- Deassert scrub_en after CHECK of addr 9 -> FSM returns to IDLE with pointer 10. Reassert -> after SCRUB_INTERVAL cycles CHECK resumes at 10; scrub_done pulses after addr 15.
